// File: rtl/tespar_pkg.sv
// Shared types for the TESPAR epoch resynthesiser: default field widths,
// the epoch descriptor layout and the engine state encoding.
package tespar_pkg;

    localparam int TESPAR_D_WIDTH = 8;
    localparam int TESPAR_S_WIDTH = 3;

    // One coded epoch: duration in samples and number of local minima.
    typedef struct packed {
        logic [TESPAR_D_WIDTH-1:0] d;
        logic [TESPAR_S_WIDTH-1:0] s;
    } epoch_desc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } synth_state_t;

endpackage

// File: rtl/tespar_epoch_synth_if.sv
// Epoch descriptor valid/ready channel feeding the resynthesiser.
import tespar_pkg::*;

interface tespar_epoch_synth_if #(
    parameter int D_WIDTH = TESPAR_D_WIDTH,
    parameter int S_WIDTH = TESPAR_S_WIDTH
) ();
    logic               epoch_valid;
    logic               epoch_ready;
    logic [D_WIDTH-1:0] epoch_d;
    logic [S_WIDTH-1:0] epoch_s;

    modport master (
        output epoch_valid,
        output epoch_d,
        output epoch_s,
        input  epoch_ready
    );

    modport slave (
        input  epoch_valid,
        input  epoch_d,
        input  epoch_s,
        output epoch_ready
    );
endinterface

// File: rtl/tespar_desc_fifo.sv
// Small synchronous descriptor FIFO with a registered occupancy count.
// Full/empty are decoded from the count so the producer-side ready
// never depends combinationally on the consumer.
module tespar_desc_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents are don't-care until written, pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/tespar_epoch_synth.sv
// TESPAR epoch resynthesiser: buffers (D, S) descriptors and regenerates a
// square-ish signed waveform, one sample per sample_tick. Each epoch is D
// samples of one polarity with S half-amplitude dips on its odd samples;
// polarity flips at every completed epoch.
import tespar_pkg::*;

module tespar_epoch_synth #(
    parameter int D_WIDTH    = TESPAR_D_WIDTH,
    parameter int S_WIDTH    = TESPAR_S_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int AMP        = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    tespar_epoch_synth_if.slave           ep,
    input  logic                          sample_tick,
    output logic signed [7:0]             sample_out,
    output logic                          sample_valid,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam logic signed [7:0] AMP_FULL = 8'(AMP);
    localparam logic signed [7:0] AMP_HALF = 8'(AMP >> 1);

    synth_state_t       state;
    logic [D_WIDTH:0]   k;
    logic [D_WIDTH-1:0] cur_d;
    logic [S_WIDTH-1:0] cur_s;
    logic               pol_neg;

    epoch_desc_t        din;
    epoch_desc_t        head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [D_WIDTH:0]   twice_s;
    logic [D_WIDTH:0]   k_last;
    logic               is_last;

    // A zero duration still produces one sample.
    function automatic logic [D_WIDTH-1:0] d_eff(input logic [D_WIDTH-1:0] d);
        return (d == '0) ? D_WIDTH'(1) : d;
    endfunction

    // Dips sit on odd samples below 2*S; polarity applies the sign.
    function automatic logic signed [7:0] shape_sample(
        input logic [D_WIDTH:0] kk,
        input logic [D_WIDTH:0] two_s,
        input logic             neg
    );
        logic signed [7:0] mag;
        mag = (kk[0] && (kk < two_s)) ? AMP_HALF : AMP_FULL;
        return neg ? -mag : mag;
    endfunction

    assign din.d          = ep.epoch_d;
    assign din.s          = ep.epoch_s;
    assign ep.epoch_ready = !fifo_full;

    tespar_desc_fifo #(
        .W     ($bits(epoch_desc_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ep.epoch_valid),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Decode the dip limit, end-of-epoch and when the engine takes the FIFO head.
    always_comb begin
        twice_s              = '0;
        twice_s[S_WIDTH:0]   = {cur_s, 1'b0};
        k_last               = {1'b0, cur_d} - (D_WIDTH + 1)'(1);
        is_last              = (k == k_last);
        pop                  = 1'b0;
        if (state == LOAD) begin
            pop = 1'b1;
        end else if (state == RUN && sample_tick && is_last && !fifo_empty) begin
            pop = 1'b1;
        end
    end

    // Engine FSM with registered sample outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            k            <= '0;
            cur_d        <= D_WIDTH'(1);
            cur_s        <= '0;
            pol_neg      <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            sample_valid <= sample_tick;
            underrun     <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        sample_out <= '0;
                        underrun   <= 1'b1;
                    end
                    if (!fifo_empty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (sample_tick) begin
                        sample_out <= '0;
                        underrun   <= 1'b1;
                    end
                    cur_d <= d_eff(head.d);
                    cur_s <= head.s;
                    k     <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (sample_tick) begin
                        sample_out <= shape_sample(k, twice_s, pol_neg);
                        if (is_last) begin
                            pol_neg <= ~pol_neg;
                            if (!fifo_empty) begin
                                cur_d <= d_eff(head.d);
                                cur_s <= head.s;
                                k     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tespar_epoch_synth.sv
// Bench for tespar_epoch_synth: expected samples are queued as ticks are
// driven and compared when sample_valid appears.
module tb_tespar_epoch_synth;
    import tespar_pkg::*;

    typedef struct {
        int smp;
        int und;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              sample_tick;
    logic signed [7:0] sample_out;
    logic              sample_valid;
    logic              underrun;
    logic [2:0]        fifo_level;

    int   checks;
    int   errors;
    exp_t sb[$];

    tespar_epoch_synth_if #(.D_WIDTH(8), .S_WIDTH(3)) ep_if ();

    tespar_epoch_synth #(
        .D_WIDTH    (8),
        .S_WIDTH    (3),
        .FIFO_DEPTH (4),
        .AMP        (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ep           (ep_if.slave),
        .sample_tick  (sample_tick),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (sample_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_sample", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sample", int'(sample_out), e.smp);
                chk("underrun", int'(underrun), e.und);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input int smp, input int und);
        exp_t e;
        e.smp = smp;
        e.und = und;
        sb.push_back(e);
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
    endtask

    task automatic push(input int d, input int s);
        ep_if.epoch_valid = 1'b1;
        ep_if.epoch_d     = 8'(d);
        ep_if.epoch_s     = 3'(s);
        @(posedge clk);
        #1;
        ep_if.epoch_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        sample_tick = 1'b0;
        ep_if.epoch_valid = 1'b0;
        ep_if.epoch_d = '0;
        ep_if.epoch_s = '0;
        cycles(2);
        chk("rst_sample_out", int'(sample_out), 0);
        chk("rst_sample_valid", int'(sample_valid), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_fifo_level", int'(fifo_level), 0);
        reset = 1'b0;
        cycles(1);
        chk("rst_ready", int'(ep_if.epoch_ready), 1);

        // Flat epoch, then the following epoch must come out negative.
        push(4, 0);
        cycles(3);
        for (int i = 0; i < 4; i++) do_tick(64, 0);
        push(1, 0);
        cycles(3);
        do_tick(-64, 0);
        cycles(3);
        chk("hold_sample_out", int'(sample_out), -64);
        chk("hold_valid_low", int'(sample_valid), 0);

        // Two epochs back to back with dips, then underrun.
        do_reset();
        push(5, 2);
        push(3, 1);
        cycles(3);
        do_tick(64, 0);  do_tick(32, 0);  do_tick(64, 0);
        do_tick(32, 0);  do_tick(64, 0);
        do_tick(-64, 0); do_tick(-32, 0); do_tick(-64, 0);
        do_tick(0, 1);

        // Boundaries: zero duration, and more dips than fit.
        do_reset();
        push(0, 3);
        push(3, 7);
        cycles(3);
        do_tick(64, 0);
        do_tick(-64, 0); do_tick(-32, 0); do_tick(-64, 0);
        do_tick(0, 1);

        // Backpressure: six pushes with no ticks.
        do_reset();
        acc = 0;
        ep_if.epoch_d = 8'd1;
        ep_if.epoch_s = 3'd0;
        ep_if.epoch_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (ep_if.epoch_ready) acc++;
            @(posedge clk);
            #1;
        end
        ep_if.epoch_valid = 1'b0;
        chk("bp_accepted", acc, 5);
        chk("bp_fifo_level", int'(fifo_level), 4);
        chk("bp_ready_low", int'(ep_if.epoch_ready), 0);
        push(1, 0);
        chk("bp_full_level", int'(fifo_level), 4);
        do_tick(64, 0);  do_tick(-64, 0); do_tick(64, 0);
        do_tick(-64, 0); do_tick(64, 0);
        do_tick(0, 1);

        // Reset in the middle of an epoch with a queued descriptor.
        do_reset();
        push(10, 0);
        push(7, 0);
        cycles(3);
        chk("mid_level_before", int'(fifo_level), 1);
        do_tick(64, 0);
        do_tick(64, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_sample_out", int'(sample_out), 0);
        chk("mid_rst_valid", int'(sample_valid), 0);
        chk("mid_rst_level", int'(fifo_level), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_ready", int'(ep_if.epoch_ready), 1);
        push(2, 0);
        cycles(3);
        do_tick(64, 0);
        do_tick(64, 0);
        do_tick(0, 1);

        cycles(3);
        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tespar_epoch_synth.md
Name: tespar_epoch_synth

Overview:
- TESPAR decoder/resynthesiser: the inverse end of the TESPAR D/S encoder chain.
- Accepts epoch descriptors (duration D, shape S) through a valid/ready handshake, buffers them in a small FIFO, and regenerates an approximate signed 8-bit waveform, one sample per sample_tick.
- Used for loopback checking of the encoder and for audible playback of coded streams.

Parameters:
- D_WIDTH, 8, width of epoch duration field (matches DS_Gen D)
- S_WIDTH, 3, width of shape field
- FIFO_DEPTH, 4, descriptor FIFO entries (power of 2, >=2)
- AMP, 64, peak magnitude of synthesised samples (1..127)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- epoch_valid  in  1  descriptor present
- epoch_ready  out  1  FIFO can accept (= FIFO not full, registered count)
- epoch_d  in  D_WIDTH  epoch duration in samples, unsigned
- epoch_s  in  S_WIDTH  number of local minima within the epoch, unsigned
- sample_tick  in  1  output sample-rate strobe, 1 cycle wide
- sample_out  out  8  signed synthesised sample
- sample_valid  out  1  1-cycle pulse, cycle after each sample_tick
- underrun  out  1  1-cycle pulse with sample_valid when no epoch was active
- fifo_level  out  clog2(FIFO_DEPTH)+1  descriptors currently stored

Behaviour:
- Reset (async): sample_out=0, sample_valid=0, underrun=0, fifo_level=0, FIFO empty, FSM=IDLE, polarity=positive. epoch_ready=1 after reset release.
- Push: on an edge with epoch_valid && epoch_ready. While full, valid is ignored and the descriptor is not stored. Push and pop in the same cycle with level < FIFO_DEPTH: level unchanged.
- D_eff = max(epoch_d, 1): D=0 is treated as 1.
- FSM IDLE: if FIFO non-empty, go to LOAD. LOAD pops the head into the engine (D_eff, S, k=0) in one cycle, then goes to RUN.
- FSM RUN, on each sample_tick: emit sample k, then k++.
  - Magnitude = AMP>>1 if (k odd and k < 2*S), else AMP.
  - sample_out = +mag if polarity is positive, -mag if negative.
  - Result: S dips, truncated when 2*S > D_eff.
- Last sample (k == D_eff-1): toggle polarity. If FIFO is non-empty, pop the next descriptor in that same cycle and stay in RUN (no gap). Otherwise go to IDLE.
- Tick while in IDLE or LOAD: sample_out=0, sample_valid=1, underrun=1. Polarity is unchanged.
- Latency: sample_valid and sample_out are registered and appear 1 cycle after sample_tick. sample_out holds its last value between ticks.
- Polarity toggles only on epoch completion, never on underrun.
- Arithmetic: k and the 2*S compare use D_WIDTH+1 bits (no overflow). Negation of AMP (<=127) fits in signed 8-bit.
- Reset mid-epoch: the epoch is discarded and the FIFO flushed. The next epoch starts positive.

Decomposition:
- tespar_pkg holds: D_WIDTH, S_WIDTH defaults; the epoch descriptor packed struct {d, s}; the FSM state enum {IDLE, LOAD, RUN}.
- One sub-module: tespar_desc_fifo (synchronous FIFO, async reset, level output).
- The synthesis engine stays in the top.

Test Plan:
- Reset: assert reset mid-run -> sample_out=0, sample_valid=0, fifo_level=0 immediately; epoch_ready=1 after release.
- Push (D=4,S=0), tick every cycle -> +64,+64,+64,+64; the next epoch starts negative.
- Push (5,2) then (3,1), continuous ticks -> +64,+32,+64,+32,+64,-64,-32,-64 back to back, no gap; the next tick gives 0 with underrun=1.
- Boundaries: (D=0,S=3) -> single +64. (D=3,S=7) -> +64,+32,+64. Polarity alternates across both epochs.
- Backpressure: sample_tick=0, push 6 descriptors back to back -> exactly 5 accepted (1 loaded, 4 stored), fifo_level=4, epoch_ready=0. Pushes while full are not stored.
- Reset during sample 2 of (D=10,S=0), then push (2,0) -> +64,+64, i.e. polarity is positive again.
